// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types for the multdiv issue wrapper: operator and FSM encodings,
// the latched request record and the intermediate-value slice width.
package ibex_multdiv_issue_pkg;

    localparam int unsigned IMD_W = 34;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_RESP = 2'd2
    } md_state_e;

    typedef struct packed {
        md_op_e      op;
        logic [1:0]  signed_mode;
        logic [31:0] op_a;
        logic [31:0] op_b;
    } md_req_t;

    function automatic logic is_mult(input md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/ibex_multdiv_issue_imd_regs.sv
// Two independent intermediate-value registers for the multdiv unit, each
// with its own write enable so the unit can update either half alone.
module ibex_multdiv_imd_regs
    import ibex_multdiv_issue_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [2*IMD_W-1:0] imd_d,
    input  logic [1:0]         imd_we,
    output logic [2*IMD_W-1:0] imd_q
);

    for (genvar i = 0; i < 2; i++) begin : g_slice
        logic [IMD_W-1:0] slice_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                slice_q <= '0;
            end else if (imd_we[i]) begin
                slice_q <= imd_d[i*IMD_W +: IMD_W];
            end
        end

        assign imd_q[i*IMD_W +: IMD_W] = slice_q;
    end

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Issue wrapper around the ibex multdiv unit: latches one request, drives the
// unit until it completes, then holds the result for writeback.
// Optional busy-cycle counter enabled by defining IBEX_MULTDIV_PERF_CNT_EN.
module ibex_multdiv_issue
    import ibex_multdiv_issue_pkg::*;
#(
    parameter bit DataIndTiming = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,

    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic [1:0]  operator_o,
    output logic [1:0]  signed_mode_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        data_ind_timing_o,
    output logic [67:0] imd_val_q_o,
    input  logic [67:0] imd_val_d_i,
    input  logic [1:0]  imd_val_we_i,
    output logic        multdiv_ready_id_o,
    input  logic [31:0] multdiv_result_i,
    input  logic        valid_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    input  logic        flush_i
`ifdef IBEX_MULTDIV_PERF_CNT_EN
    ,
    output logic [31:0] busy_cycles_o
`endif
);

    md_state_e   state_q, state_d;
    md_req_t     req_q;
    logic [31:0] result_q;
    logic        discard_q;
    logic        busy, accept, done;
    logic        mult_en, div_en;

    assign busy   = (state_q == MD_BUSY);
    assign accept = (state_q == MD_IDLE) && req_valid_i;
    assign done   = busy && valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush while busy only marks the result for discard; the unit is left
    // running so it winds back to its own idle state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q     <= '0;
            result_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            if (accept) begin
                req_q     <= '{op:          md_op_e'(req_operator_i),
                               signed_mode: req_signed_mode_i,
                               op_a:        req_op_a_i,
                               op_b:        req_op_b_i};
                discard_q <= 1'b0;
            end else if (busy && flush_i) begin
                discard_q <= 1'b1;
            end
            if (done) begin
                result_q <= multdiv_result_i;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        req_ready_o        = 1'b0;
        rsp_valid_o        = 1'b0;
        mult_en            = 1'b0;
        div_en             = 1'b0;
        multdiv_ready_id_o = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = MD_BUSY;
            end
            MD_BUSY: begin
                multdiv_ready_id_o = 1'b1;
                mult_en            = is_mult(req_q.op);
                div_en             = !is_mult(req_q.op);
                if (valid_i) state_d = (discard_q || flush_i) ? MD_IDLE : MD_RESP;
            end
            MD_RESP: begin
                // A handshake in the same cycle as a flush still completes.
                rsp_valid_o = !flush_i || rsp_ready_i;
                if (rsp_ready_i || flush_i) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign mult_en_o         = mult_en;
    assign div_en_o          = div_en;
    assign mult_sel_o        = mult_en;
    assign div_sel_o         = div_en;
    assign operator_o        = req_q.op;
    assign signed_mode_o     = req_q.signed_mode;
    assign op_a_o            = req_q.op_a;
    assign op_b_o            = req_q.op_b;
    assign data_ind_timing_o = DataIndTiming;
    assign rsp_result_o      = rsp_valid_o ? result_q : 32'd0;

    ibex_multdiv_imd_regs u_imd_regs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .imd_d  (imd_val_d_i),
        .imd_we (imd_val_we_i),
        .imd_q  (imd_val_q_o)
    );

`ifdef IBEX_MULTDIV_PERF_CNT_EN
    logic [31:0] busy_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_cnt_q <= '0;
        end else if (busy && (busy_cnt_q != 32'hFFFF_FFFF)) begin
            busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign busy_cycles_o = busy_cnt_q;
`endif

endmodule
